// File: rtl/uart_rx_deserializer.sv
`timescale 1ns/1ps
// UART receive deserializer: 16x-oversampled, frame-aligned sampling of a synchronized RX line.
// Emits one byte per frame with a single-cycle strobe plus framing/parity/break status.
module uart_rx_deserializer #(
    parameter int unsigned DIVISOR = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       par_en,
    input  logic       par_even,
    output logic [7:0] data_out,
    output logic       data_wr,
    output logic       frame_err,
    output logic       par_err,
    output logic       break_det,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    localparam logic [15:0] DIV_LAST = 16'(DIVISOR - 1);

    state_t      r_state;
    state_t      w_next_state;

    logic        r_rx_sync1;
    logic        r_rx_sync2;
    logic        r_rx_prev;
    logic [15:0] r_div_cnt;
    logic [3:0]  r_smp_cnt;
    logic [2:0]  r_bit_cnt;
    logic [7:0]  r_shift;
    logic        r_par_en;
    logic        r_par_even;
    logic        r_par_bit;
    logic        r_par_bad;

    logic        w_rx_s;
    logic        w_tick;
    logic        w_mid;
    logic        w_start;
    logic        w_shift_en;
    logic        w_par_smp;
    logic        w_stop_smp;

    // Two synchronizer stages, plus a third flop that remembers the previous rx_s for edge detection.
    // NOTE: every clocked register uses <= so all flops update from the same pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_sync1 <= 1'b1;
            r_rx_sync2 <= 1'b1;
            r_rx_prev  <= 1'b1;
        end else begin
            r_rx_sync1 <= rx;
            r_rx_sync2 <= r_rx_sync1;
            r_rx_prev  <= r_rx_sync2;
        end
    end

    assign w_rx_s = r_rx_sync2;
    assign w_tick = (r_div_cnt == DIV_LAST);
    assign w_mid  = w_tick && (r_smp_cnt == 4'd7);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: each combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:      if (w_start) w_next_state = S_START;
            S_START:     if (w_mid) w_next_state = w_rx_s ? S_IDLE : S_DATA;
            S_DATA:      if (w_mid && (r_bit_cnt == 3'd7)) w_next_state = r_par_en ? S_PARITY : S_STOP;
            S_PARITY:    if (w_mid) w_next_state = S_STOP;
            S_STOP:      if (w_mid) w_next_state = w_rx_s ? S_IDLE : S_WAIT_IDLE;
            S_WAIT_IDLE: if (w_rx_s) w_next_state = S_IDLE;
            default:     w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        busy       = (r_state != S_IDLE);
        w_start    = (r_state == S_IDLE) && r_rx_prev && !w_rx_s;
        w_shift_en = (r_state == S_DATA) && w_mid;
        w_par_smp  = (r_state == S_PARITY) && w_mid;
        w_stop_smp = (r_state == S_STOP) && w_mid;
    end

    // Restarting the divider on the start edge puts sample count 7 in the middle of every bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_div_cnt <= 16'd0;
            r_smp_cnt <= 4'd0;
            r_bit_cnt <= 3'd0;
        end else if (w_start) begin
            r_div_cnt <= 16'd0;
            r_smp_cnt <= 4'd0;
            r_bit_cnt <= 3'd0;
        end else if (busy) begin
            if (w_tick) begin
                r_div_cnt <= 16'd0;
                r_smp_cnt <= r_smp_cnt + 4'd1;
            end else begin
                r_div_cnt <= r_div_cnt + 16'd1;
            end
            if (w_shift_en) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shift    <= 8'd0;
            r_par_en   <= 1'b0;
            r_par_even <= 1'b0;
            r_par_bit  <= 1'b0;
            r_par_bad  <= 1'b0;
        end else begin
            if (w_start) begin
                r_par_en   <= par_en;
                r_par_even <= par_even;
                r_par_bit  <= 1'b0;
                r_par_bad  <= 1'b0;
            end
            if (w_shift_en) begin
                r_shift <= {w_rx_s, r_shift[7:1]};
            end
            if (w_par_smp) begin
                r_par_bit <= w_rx_s;
                r_par_bad <= (^r_shift) ^ w_rx_s ^ ~r_par_even;
            end
        end
    end

    // Byte and flags change only together with the strobe and hold until the next one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_out  <= 8'd0;
            data_wr   <= 1'b0;
            frame_err <= 1'b0;
            par_err   <= 1'b0;
            break_det <= 1'b0;
        end else begin
            data_wr <= w_stop_smp;
            if (w_stop_smp) begin
                data_out  <= r_shift;
                frame_err <= ~w_rx_s;
                par_err   <= r_par_en & r_par_bad;
                break_det <= ~w_rx_s & (r_shift == 8'd0) & (~r_par_en | ~r_par_bit);
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
`timescale 1ns/1ps
// Self-checking bench for uart_rx_deserializer: frame-level expectation queue checked every
// cycle, plus literal expectations for the directed scenarios.
module tb_uart_rx_deserializer;

    localparam int DIV = 4;
    localparam int BIT = 16 * DIV;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic       par_en;
    logic       par_even;
    logic [7:0] data_out;
    logic       data_wr;
    logic       frame_err;
    logic       par_err;
    logic       break_det;
    logic       busy;

    uart_rx_deserializer #(.DIVISOR(DIV)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .par_en    (par_en),
        .par_even  (par_even),
        .data_out  (data_out),
        .data_wr   (data_wr),
        .frame_err (frame_err),
        .par_err   (par_err),
        .break_det (break_det),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       fe;
        logic       pe;
        logic       bd;
        int         due;
    } exp_t;

    exp_t        exp_q[$];
    int          cycle = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    logic [10:0] last_out = '0;
    logic        prev_wr = 1'b0;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic check_out(input string tag, input logic [7:0] d, input logic fe,
                             input logic pe, input logic bd);
        check({tag, "_data"},      32'(data_out),  32'(d));
        check({tag, "_frame_err"}, 32'(frame_err), 32'(fe));
        check({tag, "_par_err"},   32'(par_err),   32'(pe));
        check({tag, "_break_det"}, 32'(break_det), 32'(bd));
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one frame LSB first and queues what the receiver must report for it.
    task automatic send_frame(input logic [7:0] d, input logic pe, input logic pev,
                              input logic pbit, input logic stop, input int low_bits);
        exp_t e;
        int   t0;
        int   ones;
        par_en   = pe;
        par_even = pev;
        rx       = 1'b0;
        t0       = cycle;
        wait_clks(BIT);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            wait_clks(BIT);
        end
        if (pe) begin
            rx = pbit;
            wait_clks(BIT);
        end
        ones  = $countones(d) + int'(pbit);
        e.d   = d;
        e.fe  = ~stop;
        e.pe  = pe && (pev ? (ones % 2 == 1) : (ones % 2 == 0));
        e.bd  = ~stop && (d == 8'h00) && (!pe || !pbit);
        e.due = t0 + 2 + (9 + int'(pe)) * BIT + BIT / 2;
        exp_q.push_back(e);
        rx = stop;
        wait_clks(stop ? BIT : BIT * low_bits);
        if (!stop) check("wait_idle_busy", 32'(busy), 32'd1);
        rx = 1'b1;
        wait_clks(BIT);
        check("idle_after_frame", 32'(busy), 32'd0);
    endtask

    // Per-cycle comparison of the outputs against the frame-level model.
    always @(negedge clk) begin
        if (!reset) begin
            last_out = '0;
            prev_wr  = 1'b0;
        end else begin
            if (data_wr) begin
                check("wr_single_cycle", 32'(prev_wr), 32'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", 32'(exp_q.size()), 32'd1);
                end else begin
                    exp_t e;
                    int   diff;
                    e    = exp_q.pop_front();
                    diff = cycle - e.due;
                    check("strobe_latency_in_window", 32'(diff >= -1 && diff <= 1), 32'd1);
                    if (diff < -1 || diff > 1) $display("  latency offset %0d clks", diff);
                    check("strobe_fields", 32'({data_out, frame_err, par_err, break_det}),
                          32'({e.d, e.fe, e.pe, e.bd}));
                    last_out = {e.d, e.fe, e.pe, e.bd};
                end
            end else begin
                check("outputs_held", 32'({data_out, frame_err, par_err, break_det}), 32'(last_out));
                if (exp_q.size() != 0 && cycle == exp_q[0].due + 2) begin
                    check("strobe_missing", 32'(data_wr), 32'd1);
                    void'(exp_q.pop_front());
                end
            end
            prev_wr = data_wr;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cycle);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset    = 1'b0;
        rx       = 1'b1;
        par_en   = 1'b0;
        par_even = 1'b0;
        wait_clks(3);
        check_out("reset_init", 8'h00, 1'b0, 1'b0, 1'b0);
        check("reset_init_busy", 32'(busy), 32'd0);
        check("reset_init_wr", 32'(data_wr), 32'd0);
        reset = 1'b1;
        wait_clks(10);

        send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1);
        check_out("f55", 8'h55, 1'b0, 1'b0, 1'b0);

        // 0xA3 has four ones: even parity needs bit 0, odd parity needs bit 1.
        send_frame(8'hA3, 1'b1, 1'b1, 1'b0, 1'b1, 1);
        check_out("fA3_even_ok", 8'hA3, 1'b0, 1'b0, 1'b0);
        send_frame(8'hA3, 1'b1, 1'b1, 1'b1, 1'b1, 1);
        check_out("fA3_even_bad", 8'hA3, 1'b0, 1'b1, 1'b0);
        send_frame(8'hA3, 1'b1, 1'b0, 1'b1, 1'b1, 1);
        send_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1);

        // Start-bit glitch shorter than half a bit.
        rx = 1'b0;
        wait_clks(10);
        check("glitch_busy", 32'(busy), 32'd1);
        wait_clks(10);
        rx = 1'b1;
        wait_clks(40);
        check("glitch_back_idle", 32'(busy), 32'd0);
        check_out("glitch_hold", 8'h00, 1'b0, 1'b0, 1'b0);

        send_frame(8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1);
        check_out("fbreak", 8'h00, 1'b1, 1'b0, 1'b1);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 3);
        check_out("f3C_frame", 8'h3C, 1'b1, 1'b0, 1'b0);

        // Reset in the middle of an 0xFF frame.
        par_en = 1'b0;
        rx     = 1'b0;
        wait_clks(BIT);
        rx = 1'b1;
        wait_clks(3 * BIT);
        reset = 1'b0;
        #1;
        check_out("mid_reset", 8'h00, 1'b0, 1'b0, 1'b0);
        check("mid_reset_busy", 32'(busy), 32'd0);
        check("mid_reset_wr", 32'(data_wr), 32'd0);
        wait_clks(5);
        reset = 1'b1;
        wait_clks(BIT);

        send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 1);
        check_out("f81", 8'h81, 1'b0, 1'b0, 1'b0);

        wait_clks(BIT);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
